// File: rtl/axi_mem_responder_if.sv
// AXI4 bus bundle between a cache-side initiator and axi_mem_responder.
// Carries the AW, W, B, AR and R channels. The slave modport is used by the
// responder. The master modport is for an initiator or a testbench driver.
// Port names keep the responder's i_/o_ orientation so that both ends read the same.
interface axi_mem_responder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  i_awvalid;
  logic                  o_awready;
  logic [ADDR_WIDTH-1:0] i_awaddr;
  logic [7:0]            i_awlen;
  logic                  i_wvalid;
  logic                  o_wready;
  logic [31:0]           i_wdata;
  logic [3:0]            i_wstrb;
  logic                  i_wlast;
  logic                  o_bvalid;
  logic                  i_bready;
  logic [1:0]            o_bresp;
  logic                  i_arvalid;
  logic                  o_arready;
  logic [ADDR_WIDTH-1:0] i_araddr;
  logic [7:0]            i_arlen;
  logic                  o_rvalid;
  logic                  i_rready;
  logic [31:0]           o_rdata;
  logic                  o_rlast;
  logic [1:0]            o_rresp;

  modport slave (
    input  i_awvalid, i_awaddr, i_awlen, i_wvalid, i_wdata, i_wstrb, i_wlast,
           i_bready, i_arvalid, i_araddr, i_arlen, i_rready,
    output o_awready, o_wready, o_bvalid, o_bresp, o_arready, o_rvalid,
           o_rdata, o_rlast, o_rresp
  );

  modport master (
    output i_awvalid, i_awaddr, i_awlen, i_wvalid, i_wdata, i_wstrb, i_wlast,
           i_bready, i_arvalid, i_araddr, i_arlen, i_rready,
    input  o_awready, o_wready, o_bvalid, o_bresp, o_arready, o_rvalid,
           o_rdata, o_rlast, o_rresp
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 memory-side responder. It serves INCR burst line fills and
// writebacks from a word-addressed internal array. A single FSM serialises
// reads and writes: IDLE -> READ -> IDLE and IDLE -> WRITE -> WRESP -> IDLE.
// Ports:
//   clk  - clock
//   arst - asynchronous active-high reset. It aborts any burst. Memory
//          contents are kept.
//   bus  - AXI AW/W/B/AR/R channels (axi_mem_responder_if.slave)
module axi_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 4096,
  parameter int MAX_LEN    = 15
) (
  input  logic                clk,
  input  logic                arst,
  axi_mem_responder_if.slave  bus
);
  localparam int         IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, READ, WRITE, WRESP} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg;
  logic [7:0]       len_reg;
  logic [7:0]       cnt_reg;
  logic             err_reg;      // the write burst will answer SLVERR
  logic             len_bad_reg;  // AxLEN above MAX_LEN: no writes, reads return 0
  logic [31:0]      rdata_reg;

  logic             last_beat;
  logic             aw_hs, ar_hs, w_hs, w_end, w_bad, r_adv;
  logic             mem_we;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_word;

  assign last_beat = (cnt_reg == len_reg);
  // Write has priority in IDLE, so a pending AW masks AR.
  assign aw_hs = (state_reg == IDLE) && bus.i_awvalid;
  assign ar_hs = (state_reg == IDLE) && bus.i_arvalid && !bus.i_awvalid;
  assign w_hs  = (state_reg == WRITE) && bus.i_wvalid;
  // A burst ends on the first of wlast or the final counted beat.
  // The burst is an error if wlast and the final counted beat do not coincide.
  assign w_end = w_hs && (bus.i_wlast || last_beat);
  assign w_bad = w_hs && (bus.i_wlast != last_beat);
  assign r_adv = (state_reg == READ) && bus.i_rready && !last_beat;
  assign mem_we = w_hs && !len_bad_reg;

  // Read address: the new burst start in IDLE, else the next beat's word.
  assign rd_idx = (state_reg == IDLE) ? bus.i_araddr[IDX_W+1:2] : idx_reg + 1'b1;

  // One byte-wide array per lane, so wstrb maps directly to lane write enables.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_DEPTH];
      always_ff @(posedge clk) begin
        if (mem_we && bus.i_wstrb[gi]) begin
          lane_mem[idx_reg] <= bus.i_wdata[gi*8 +: 8];
        end
      end
      assign rd_word[gi*8 +: 8] = lane_mem[rd_idx];
    end
  endgenerate

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bus.o_awready = 1'b0;
    bus.o_arready = 1'b0;
    bus.o_wready  = 1'b0;
    bus.o_bvalid  = 1'b0;
    bus.o_rvalid  = 1'b0;
    bus.o_rlast   = 1'b0;
    bus.o_bresp   = 2'b00;
    bus.o_rresp   = 2'b00;
    case (state_reg)
      IDLE: begin
        bus.o_awready = 1'b1;
        bus.o_arready = !bus.i_awvalid;
        if (aw_hs) begin
          state_next = WRITE;
        end else if (ar_hs) begin
          state_next = READ;
        end
      end
      READ: begin
        bus.o_rvalid = 1'b1;
        bus.o_rlast  = last_beat;
        bus.o_rresp  = len_bad_reg ? 2'b10 : 2'b00;
        if (bus.i_rready && last_beat) begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        bus.o_wready = 1'b1;
        if (w_end) begin
          state_next = WRESP;
        end
      end
      WRESP: begin
        bus.o_bvalid = 1'b1;
        bus.o_bresp  = err_reg ? 2'b10 : 2'b00;
        if (bus.i_bready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      idx_reg     <= '0;
      len_reg     <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
      len_bad_reg <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      if (aw_hs) begin
        idx_reg     <= bus.i_awaddr[IDX_W+1:2];
        len_reg     <= bus.i_awlen;
        cnt_reg     <= '0;
        len_bad_reg <= (bus.i_awlen > MAX_LEN_B);
        err_reg     <= (bus.i_awlen > MAX_LEN_B);
      end else if (ar_hs) begin
        idx_reg     <= rd_idx;
        len_reg     <= bus.i_arlen;
        cnt_reg     <= '0;
        len_bad_reg <= (bus.i_arlen > MAX_LEN_B);
        rdata_reg   <= (bus.i_arlen > MAX_LEN_B) ? 32'h0 : rd_word;
      end
      if (r_adv) begin
        cnt_reg   <= cnt_reg + 8'd1;
        idx_reg   <= rd_idx;
        rdata_reg <= len_bad_reg ? 32'h0 : rd_word;
      end
      if (w_hs) begin
        if (w_bad) begin
          err_reg <= 1'b1;
        end
        if (!w_end) begin
          cnt_reg <= cnt_reg + 8'd1;
          idx_reg <= idx_reg + 1'b1;
        end
      end
    end
  end

  assign bus.o_rdata = rdata_reg;
endmodule

// File: tb/tb_axi_mem_responder.sv
module tb_axi_mem_responder;
  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  axi_mem_responder_if #(.ADDR_WIDTH(32)) bus ();

  axi_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(4096), .MAX_LEN(15)
  ) dut (
    .clk (clk),
    .arst(arst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]  resp;
    logic        last;
    logic [31:0] data;
  } rbeat_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [int];
  rbeat_t      exp_q [$];
  logic [1:0]  bexp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] addr, input int i);
    return (int'(addr[13:2]) + i) % 4096;
  endfunction

  function automatic logic rdy(input int which);
    case (which)
      0:       return bus.o_awready;
      1:       return bus.o_wready;
      2:       return bus.o_arready;
      default: return bus.o_bvalid;
    endcase
  endfunction

  // Returns at a negedge where the selected ready is high, or flags a timeout.
  task automatic wait_ready(input int which, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy(which) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check(tag, 32'h0, 32'h1);
  endtask

  // Write burst. last_at is the beat that carries wlast (-1 means none).
  task automatic do_write(input logic [31:0] addr, input int len, input int last_at,
                          input logic [31:0] base, input logic [3:0] strb);
    int          nb;
    int          k;
    logic [31:0] w;
    logic [1:0]  eb;
    nb = (last_at >= 0 && last_at < len) ? last_at + 1 : len + 1;
    eb = (len > 15 || last_at != len) ? 2'b10 : 2'b00;
    bus.i_awvalid = 1'b1;
    bus.i_awaddr  = addr;
    bus.i_awlen   = len[7:0];
    wait_ready(0, "aw_timeout");
    @(posedge clk); #1;
    bus.i_awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      bus.i_wvalid = 1'b1;
      bus.i_wdata  = base + i;
      bus.i_wstrb  = strb;
      bus.i_wlast  = (i == last_at);
      wait_ready(1, "w_timeout");
      @(posedge clk); #1;
      if (len <= 15) begin
        k = widx(addr, i);
        w = model.exists(k) ? model[k] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (strb[b]) w[b*8 +: 8] = bus.i_wdata[b*8 +: 8];
        model[k] = w;
      end
    end
    bus.i_wvalid = 1'b0;
    bus.i_wlast  = 1'b0;
    bexp_q.push_back(eb);
    @(negedge clk);
    check("b_latency", bus.o_bvalid, 1'b1);
    check("bresp", bus.o_bresp, bexp_q.pop_front());
    bus.i_bready = 1'b1;
    @(posedge clk); #1;
    bus.i_bready = 1'b0;
    @(negedge clk);
    check("bvalid_drop", bus.o_bvalid, 1'b0);
    $display("write addr=%h len=%0d beats=%0d bresp=%b", addr, len, nb, eb);
    @(posedge clk); #1;
  endtask

  task automatic push_read(input logic [31:0] addr, input int len);
    rbeat_t e;
    for (int i = 0; i <= len; i++) begin
      e.resp = (len > 15) ? 2'b10 : 2'b00;
      e.last = (i == len);
      e.data = (len > 15) ? 32'h0 : model[widx(addr, i)];
      exp_q.push_back(e);
    end
  endtask

  task automatic issue_read(input logic [31:0] addr, input int len);
    bus.i_arvalid = 1'b1;
    bus.i_araddr  = addr;
    bus.i_arlen   = len[7:0];
    wait_ready(2, "ar_timeout");
    push_read(addr, len);
    @(posedge clk); #1;
    bus.i_arvalid = 1'b0;
  endtask

  // Collects R beats against the scoreboard. Stalled beats are compared to
  // the same queue head, so any change while stalled is caught.
  // abort_at >= 0 asserts arst while that beat is being presented.
  task automatic collect_read(input logic [3:0] pat, input int abort_at);
    int     c;
    int     beat;
    rbeat_t e;
    c = 0;
    beat = 0;
    while (exp_q.size() > 0 && c < 200) begin
      bus.i_rready = pat[c % 4];
      @(negedge clk);
      e = exp_q[0];
      check("rvalid", bus.o_rvalid, 1'b1);
      check("rdata", bus.o_rdata, e.data);
      check("rlast", bus.o_rlast, e.last);
      check("rresp", bus.o_rresp, e.resp);
      if (beat == abort_at) begin
        #1 arst = 1'b1;
        #1;
        check("rst_rvalid", bus.o_rvalid, 1'b0);
        check("rst_awready", bus.o_awready, 1'b1);
        check("rst_rlast", bus.o_rlast, 1'b0);
        $display("reset asserted at read beat %0d", beat);
        exp_q.delete();
        bus.i_rready = 1'b0;
        @(posedge clk); #2;
        arst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (bus.i_rready) begin
        $display("read beat %0d data=%h last=%b", beat, bus.o_rdata, bus.o_rlast);
        void'(exp_q.pop_front());
        beat++;
      end
      @(posedge clk); #1;
      c++;
    end
    if (c >= 200) check("r_timeout", 32'h0, 32'h1);
    bus.i_rready = 1'b0;
    @(negedge clk);
    check("rvalid_drop", bus.o_rvalid, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.i_awvalid = 0; bus.i_awaddr = 0; bus.i_awlen = 0;
    bus.i_wvalid = 0; bus.i_wdata = 0; bus.i_wstrb = 0; bus.i_wlast = 0;
    bus.i_bready = 0; bus.i_arvalid = 0; bus.i_araddr = 0; bus.i_arlen = 0;
    bus.i_rready = 0;
    arst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", bus.o_awready, 1'b1);
    check("rst_arready", bus.o_arready, 1'b1);
    check("rst_wready", bus.o_wready, 1'b0);
    check("rst_bvalid", bus.o_bvalid, 1'b0);
    check("rst_rvalid", bus.o_rvalid, 1'b0);
    check("rst_rlast", bus.o_rlast, 1'b0);
    check("rst_rdata", bus.o_rdata, 32'h0);
    check("rst_bresp", bus.o_bresp, 2'b00);
    check("rst_rresp", bus.o_rresp, 2'b00);
    arst = 1'b0;
    @(posedge clk); #1;

    // Full cache block write followed by readback at full rate.
    do_write(32'h100, 15, 15, 32'hA0, 4'hF);
    issue_read(32'h100, 15);
    collect_read(4'hF, -1);

    // Read with backpressure pattern 1,0,0,1.
    issue_read(32'h100, 3);
    collect_read(4'b1001, -1);

    // Partial strobe merge.
    do_write(32'h100, 0, 0, 32'hFFFFFFFF, 4'hF);
    do_write(32'h100, 0, 0, 32'h12345678, 4'b0101);
    issue_read(32'h100, 0);
    collect_read(4'hF, -1);

    // AW and AR in the same IDLE cycle: write first, AR waits for B.
    bus.i_awvalid = 1'b1; bus.i_awaddr = 32'h300; bus.i_awlen = 8'd0;
    bus.i_arvalid = 1'b1; bus.i_araddr = 32'h300; bus.i_arlen = 8'd0;
    @(negedge clk);
    check("simul_awready", bus.o_awready, 1'b1);
    check("simul_arready", bus.o_arready, 1'b0);
    @(posedge clk); #1;
    bus.i_awvalid = 1'b0;
    bus.i_wvalid = 1'b1; bus.i_wdata = 32'hDEADBEEF; bus.i_wstrb = 4'hF; bus.i_wlast = 1'b1;
    @(negedge clk);
    check("wr_wready", bus.o_wready, 1'b1);
    check("wr_arready", bus.o_arready, 1'b0);
    @(posedge clk); #1;
    bus.i_wvalid = 1'b0; bus.i_wlast = 1'b0;
    model[widx(32'h300, 0)] = 32'hDEADBEEF;
    @(negedge clk);
    check("wresp_bvalid", bus.o_bvalid, 1'b1);
    check("wresp_arready", bus.o_arready, 1'b0);
    check("wresp_bresp", bus.o_bresp, 2'b00);
    bus.i_bready = 1'b1;
    @(posedge clk); #1;
    bus.i_bready = 1'b0;
    @(negedge clk);
    check("post_b_arready", bus.o_arready, 1'b1);
    push_read(32'h300, 0);
    $display("simultaneous AW/AR: write done, AR accepted");
    @(posedge clk); #1;
    bus.i_arvalid = 1'b0;
    collect_read(4'hF, -1);

    // Early wlast: only beats 0..2 change.
    do_write(32'h400, 3, 3, 32'h11, 4'hF);
    do_write(32'h400, 3, 2, 32'h50, 4'hF);
    issue_read(32'h400, 3);
    collect_read(4'hF, -1);
    // Oversized burst: fully accepted, SLVERR, memory untouched.
    do_write(32'h400, 20, 20, 32'h70, 4'hF);
    issue_read(32'h400, 3);
    collect_read(4'hF, -1);
    // Counter reaches len without wlast: SLVERR, both beats still written.
    do_write(32'h500, 1, -1, 32'h90, 4'hF);
    issue_read(32'h500, 1);
    collect_read(4'hF, -1);
    // Oversized read: zeros with SLVERR on every beat.
    issue_read(32'h400, 16);
    collect_read(4'hF, -1);

    // Reset mid-read, then memory must be intact.
    issue_read(32'h100, 15);
    collect_read(4'hF, 5);
    @(negedge clk);
    check("post_rst_rvalid", bus.o_rvalid, 1'b0);
    check("post_rst_awready", bus.o_awready, 1'b1);
    @(posedge clk); #1;
    issue_read(32'h100, 3);
    collect_read(4'hF, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 memory-side responder (slave). It serves the burst line fills and dirty-line writebacks that the instruction and data cache FSMs issue through the core's AXI initiator.
- Backed by a single-port word-addressed internal memory array.
- Handles INCR bursts only. Reads and writes are serialised through one FSM, so the same block acts as main memory in simulation and in simple FPGA builds.

Parameters:
- ADDR_WIDTH, 32, byte address width on AR/AW.
- DATA_WIDTH, 32, data bus width. Fixed at 32; WSTRB is 4 bits.
- MEM_DEPTH, 4096, number of 32-bit words in the array. Must be a power of two.
- MAX_LEN, 15, largest accepted AxLEN, giving 16 beats (one cache block).

Ports:
- clk  in  1  clock.
- arst  in  1  asynchronous active-high reset.
- i_awvalid  in  1  write address valid.
- o_awready  out  1  write address ready.
- i_awaddr  in  ADDR_WIDTH  write burst start byte address.
- i_awlen  in  8  write beats minus 1.
- i_wvalid  in  1  write data valid.
- o_wready  out  1  write data ready.
- i_wdata  in  32  write data.
- i_wstrb  in  4  byte enables.
- i_wlast  in  1  last write beat.
- o_bvalid  out  1  write response valid.
- i_bready  in  1  write response ready.
- o_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- i_arvalid  in  1  read address valid.
- o_arready  out  1  read address ready.
- i_araddr  in  ADDR_WIDTH  read burst start byte address.
- i_arlen  in  8  read beats minus 1.
- o_rvalid  out  1  read data valid.
- i_rready  in  1  read data ready.
- o_rdata  out  32  read data (registered).
- o_rlast  out  1  last read beat.
- o_rresp  out  2  read response: 00 OKAY, 10 SLVERR.

Behaviour:
- FSM states: IDLE, READ, WRITE, WRESP. State resets to IDLE.
- Reset values: o_wready, o_bvalid, o_rvalid and o_rlast are 0; o_rdata, o_bresp and o_rresp are 0. In IDLE, o_awready is 1 and o_arready is ~i_awvalid. Both readies are combinational from state.
- Reset mid-burst: the burst is aborted and the FSM returns to IDLE. Memory contents are retained and are never cleared by reset. Array contents after power-up are undefined.
- Arbitration in IDLE: write wins if i_awvalid and i_arvalid are both high. The writeback therefore precedes the refill.
- Addressing: word index = addr[2+log2(MEM_DEPTH)-1:2]. addr[1:0] and higher bits are ignored (aliasing). The index increments by 1 per beat and wraps modulo MEM_DEPTH.
- AxLEN > MAX_LEN: the burst is still accepted and fully serviced, but every response for it is SLVERR. A rejected write burst does not modify memory; a rejected read burst returns rdata = 0.
- IDLE -> READ on the AR handshake. Capture the index and len, clear the beat counter, and load o_rdata from mem[index]. o_rvalid rises the next cycle.
- READ:
  - o_rvalid is held high.
  - o_rlast = (beat counter == len).
  - On i_rready with rlast low: increment the counter and index, and load the next word, so one beat per cycle is sustained.
  - On i_rready with rlast high: go to IDLE; o_rvalid drops the next cycle.
  - If i_rready is low, o_rdata/o_rlast are held stable.
  - Latency: AR accepted at cycle T gives the first beat at T+1. With i_rready held, the last beat is at T+1+len.
- IDLE -> WRITE on the AW handshake. Capture the index and len, and clear the counter and error flag.
- WRITE:
  - o_wready is 1.
  - On each W handshake: write the bytes with wstrb set; bytes with wstrb clear are unchanged.
  - i_wlast high before counter == len sets the error flag and ends the burst: go to WRESP.
  - Counter == len with i_wlast low also sets the error flag and goes to WRESP.
  - Otherwise increment the counter and index.
- WRESP:
  - o_wready is 0 and o_bvalid is 1.
  - o_bresp = 10 if the error flag is set, else 00.
  - Hold until i_bready, then go to IDLE; o_bvalid drops the next cycle.
  - B is valid the cycle after the last W handshake.
- No outstanding-transaction overlap: a new AR or AW is accepted only in IDLE.

Test Plan:
- Write 16 beats at 0x100 (awlen=15, data 0xA0+i, wstrb=F, wlast on beat 15), then read 16 beats at 0x100 -> bresp=00; rdata = 0xA0..0xAF; rlast only on beat 15; first rvalid 1 cycle after the AR handshake.
- i_rready toggled 1,0,0,1 during the read of 4 words -> o_rdata/o_rlast stable while stalled; no beat skipped or duplicated.
- Partial strobe: word 0x40 = 0xFFFFFFFF, then write 0x12345678 with wstrb=0101 -> readback 0xFF34FF78.
- AW and AR valid in the same IDLE cycle -> AW accepted first and o_arready=0 that cycle; AR accepted only after the B handshake; the read returns the newly written data.
- Early wlast on beat 2 of awlen=3 -> bresp=10, only beats 0..2 written; an awlen=20 burst -> all beats accepted, bresp=10, memory unchanged.
- arst asserted mid-read at beat 5 -> o_rvalid=0 immediately, state IDLE, o_awready=1; a subsequent read returns the previously written data intact.
